// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared mode encodings, button indices and FSM state type for the game front end
package game_pkg;

    localparam logic [2:0] MODE_MENU     = 3'd0;
    localparam logic [2:0] MODE_CLASSIC  = 3'd1;
    localparam logic [2:0] MODE_INFINITY = 3'd2;
    localparam logic [2:0] MODE_PAUSE    = 3'd4;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    // State codes equal the mode codes so the mode output is the state itself
    typedef enum logic [2:0] {
        ST_MENU     = MODE_MENU,
        ST_CLASSIC  = MODE_CLASSIC,
        ST_INFINITY = MODE_INFINITY,
        ST_PAUSE    = MODE_PAUSE
    } game_state_t;

endpackage

// File: rtl/game_debounce.sv
// rtl/game_debounce.sv - 1-bit synchroniser, tick-sampled history and debounced level register
module game_debounce #(
    parameter int N_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level
);

    logic                 sync1;
    logic                 sync2;
    logic [N_SAMPLES-1:0] hist;
    logic [N_SAMPLES-1:0] hist_nxt;

    assign hist_nxt = {hist[N_SAMPLES-2:0], sync2};

    // Level follows the history only once every sample agrees; mixed history holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                hist <= hist_nxt;
                if (&hist_nxt) begin
                    level <= 1'b1;
                end else if (~|hist_nxt) begin
                    level <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/game_input_ctrl.sv
// rtl/game_input_ctrl.sv - switch/button debounce, button edge pulses and game-selection FSM
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int N_SAMPLES       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_raw,
    input  logic [4:0]  btn_raw,
    input  logic        game_over_classic,
    input  logic        game_over_infinity,
    output logic [15:0] sw,
    output logic [4:0]  btn_pulse,
    output logic [2:0]  mode,
    output logic        menu_sel,
    output logic        enable_game_classic,
    output logic        enable_game_infinity
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] presc_cnt;
    logic          tick;
    logic [20:0]   raw_all;
    logic [20:0]   lvl_all;
    logic [4:0]    btn_lvl;
    logic [4:0]    btn_lvl_d;

    game_state_t   state;
    game_state_t   state_nxt;
    logic          sel_nxt;
    logic          p_l;
    logic          p_r;
    logic          p_c;
    logic          abort;
    logic          pause_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (presc_cnt == CNT_MAX) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    assign tick    = (presc_cnt == CNT_MAX);
    assign raw_all = {btn_raw, sw_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 21; gi++) begin : g_deb
            game_debounce #(
                .N_SAMPLES (N_SAMPLES)
            ) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .raw   (raw_all[gi]),
                .level (lvl_all[gi])
            );
        end
    endgenerate

    assign sw      = lvl_all[15:0];
    assign btn_lvl = lvl_all[20:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_lvl_d <= '0;
            btn_pulse <= '0;
        end else begin
            btn_lvl_d <= btn_lvl;
            btn_pulse <= btn_lvl & ~btn_lvl_d;
        end
    end

    assign p_l        = btn_pulse[BTN_L];
    assign p_r        = btn_pulse[BTN_R];
    assign p_c        = btn_pulse[BTN_C];
    assign abort      = sw[0];
    assign pause_over = menu_sel ? game_over_infinity : game_over_classic;

    // Each branch is ordered abort > game_over > C > L/R
    always_comb begin
        state_nxt = state;
        sel_nxt   = menu_sel;
        case (state)
            ST_MENU: begin
                if (p_c) begin
                    state_nxt = menu_sel ? ST_INFINITY : ST_CLASSIC;
                end else if (p_l && !p_r) begin
                    sel_nxt = 1'b0;
                end else if (p_r && !p_l) begin
                    sel_nxt = 1'b1;
                end
            end
            ST_CLASSIC: begin
                if (abort || game_over_classic) begin
                    state_nxt = ST_MENU;
                end else if (p_c) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_INFINITY: begin
                if (abort || game_over_infinity) begin
                    state_nxt = ST_MENU;
                end else if (p_c) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (abort || pause_over) begin
                    state_nxt = ST_MENU;
                end else if (p_c) begin
                    state_nxt = menu_sel ? ST_INFINITY : ST_CLASSIC;
                end
            end
            default: begin
                state_nxt = ST_MENU;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_MENU;
            menu_sel             <= 1'b0;
            mode                 <= MODE_MENU;
            enable_game_classic  <= 1'b0;
            enable_game_infinity <= 1'b0;
        end else begin
            state                <= state_nxt;
            menu_sel             <= sel_nxt;
            mode                 <= state_nxt;
            enable_game_classic  <= (state_nxt == ST_CLASSIC)  || ((state_nxt == ST_PAUSE) && !sel_nxt);
            enable_game_infinity <= (state_nxt == ST_INFINITY) || ((state_nxt == ST_PAUSE) &&  sel_nxt);
        end
    end

endmodule

// File: tb/tb_game_input_ctrl.sv
// tb/tb_game_input_ctrl.sv - directed self-checking bench for game_input_ctrl
module tb_game_input_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic [4:0]  btn_raw;
    logic        game_over_classic;
    logic        game_over_infinity;
    logic [15:0] sw;
    logic [4:0]  btn_pulse;
    logic [2:0]  mode;
    logic        menu_sel;
    logic        enable_game_classic;
    logic        enable_game_infinity;

    int total = 0;
    int bad   = 0;

    game_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .N_SAMPLES       (3)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sw_raw               (sw_raw),
        .btn_raw              (btn_raw),
        .game_over_classic    (game_over_classic),
        .game_over_infinity   (game_over_infinity),
        .sw                   (sw),
        .btn_pulse            (btn_pulse),
        .mode                 (mode),
        .menu_sel             (menu_sel),
        .enable_game_classic  (enable_game_classic),
        .enable_game_infinity (enable_game_infinity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a button until its pulse is observed; returns with the pulse cycle current
    task automatic hold_until_pulse(input int idx, output bit ok);
        ok = 1'b0;
        btn_raw[idx] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (btn_pulse[idx]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_btn(input int idx);
        btn_raw[idx] = 1'b0;
        repeat (20) step();
    endtask

    task automatic press(input int idx, input string name);
        bit ok;
        hold_until_pulse(idx, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL press_%s: pulse seen=%0b required=1", name, ok);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sw_raw  = 16'($urandom);
            btn_raw = 5'($urandom);
            step();
        end
        total++;
        if ({sw, btn_pulse, mode, menu_sel, enable_game_classic, enable_game_infinity} !== 26'd0) begin
            bad++;
            $display("FAIL reset_hold: sw=%h pulse=%b mode=%0d sel=%b enc=%b eni=%b required all 0",
                     sw, btn_pulse, mode, menu_sel, enable_game_classic, enable_game_infinity);
        end
        sw_raw  = '0;
        btn_raw = '0;
        step();
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 100; k++) begin
                step();
                if ({sw, btn_pulse, mode, menu_sel, enable_game_classic, enable_game_infinity} !== 26'd0)
                    seen++;
            end
            total++;
            if (seen != 0) begin
                bad++;
                $display("FAIL reset_idle: cycles with nonzero outputs=%0d required=0", seen);
            end
        end
    endtask

    task automatic test_debounce();
        int pulses = 0;
        int first  = -1;
        btn_raw[4] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (btn_pulse[4]) pulses++;
        end
        btn_raw[4] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (btn_pulse[4]) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL glitch: pulses=%0d required=0", pulses);
        end
        btn_raw[4] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (btn_pulse[4]) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL held_count: pulses=%0d required=1", pulses);
        end
        total++;
        if (first < 11 || first > 15) begin
            bad++;
            $display("FAIL held_latency: first pulse at cycle %0d required 11..15", first);
        end
        total++;
        if (mode !== 3'd1) begin
            bad++;
            $display("FAIL menu_c_classic: mode=%0d required=1", mode);
        end
        release_btn(4);
        game_over_classic = 1'b1;
        step();
        game_over_classic = 1'b0;
        total++;
        if (mode !== 3'd0 || enable_game_classic !== 1'b0) begin
            bad++;
            $display("FAIL gameover_classic: mode=%0d enc=%b required mode=0 enc=0", mode, enable_game_classic);
        end
    endtask

    task automatic test_start_infinity();
        press(1, "r");
        total++;
        if (menu_sel !== 1'b1 || mode !== 3'd0) begin
            bad++;
            $display("FAIL sel_right: sel=%b mode=%0d required sel=1 mode=0", menu_sel, mode);
        end
        release_btn(1);
        press(4, "c");
        total++;
        if (mode !== 3'd2 || enable_game_infinity !== 1'b1 || enable_game_classic !== 1'b0 || menu_sel !== 1'b1) begin
            bad++;
            $display("FAIL start_inf: mode=%0d eni=%b enc=%b sel=%b required 2 1 0 1",
                     mode, enable_game_infinity, enable_game_classic, menu_sel);
        end
        release_btn(4);
        game_over_classic = 1'b1;
        step();
        game_over_classic = 1'b0;
        step();
        total++;
        if (mode !== 3'd2 || enable_game_infinity !== 1'b1) begin
            bad++;
            $display("FAIL wrong_gameover: mode=%0d eni=%b required mode=2 eni=1", mode, enable_game_infinity);
        end
        game_over_infinity = 1'b1;
        step();
        game_over_infinity = 1'b0;
        total++;
        if (mode !== 3'd0 || enable_game_infinity !== 1'b0 || menu_sel !== 1'b1) begin
            bad++;
            $display("FAIL gameover_inf: mode=%0d eni=%b sel=%b required 0 0 1", mode, enable_game_infinity, menu_sel);
        end
    endtask

    task automatic test_l_and_r();
        bit ok;
        btn_raw[0] = 1'b1;
        hold_until_pulse(1, ok);
        total++;
        if (ok !== 1'b1 || btn_pulse[0] !== 1'b1) begin
            bad++;
            $display("FAIL lr_pulses: r=%b l=%b required both 1", ok, btn_pulse[0]);
        end
        step();
        total++;
        if (menu_sel !== 1'b1) begin
            bad++;
            $display("FAIL lr_nochange: sel=%b required=1", menu_sel);
        end
        btn_raw[0] = 1'b0;
        release_btn(1);
    endtask

    task automatic test_pause_resume();
        press(0, "l");
        release_btn(0);
        total++;
        if (menu_sel !== 1'b0) begin
            bad++;
            $display("FAIL sel_left: sel=%b required=0", menu_sel);
        end
        press(4, "c");
        release_btn(4);
        total++;
        if (mode !== 3'd1) begin
            bad++;
            $display("FAIL start_classic: mode=%0d required=1", mode);
        end
        press(4, "c");
        total++;
        if (mode !== 3'd4 || enable_game_classic !== 1'b1 || enable_game_infinity !== 1'b0) begin
            bad++;
            $display("FAIL pause: mode=%0d enc=%b eni=%b required 4 1 0", mode, enable_game_classic, enable_game_infinity);
        end
        release_btn(4);
        press(4, "c");
        total++;
        if (mode !== 3'd1 || enable_game_classic !== 1'b1) begin
            bad++;
            $display("FAIL resume: mode=%0d enc=%b required 1 1", mode, enable_game_classic);
        end
        release_btn(4);
    endtask

    task automatic test_coincident();
        bit ok;
        hold_until_pulse(4, ok);
        game_over_classic = 1'b1;
        step();
        game_over_classic = 1'b0;
        total++;
        if (ok !== 1'b1 || mode !== 3'd0 || enable_game_classic !== 1'b0 || enable_game_infinity !== 1'b0) begin
            bad++;
            $display("FAIL coincident: pulse=%b mode=%0d enc=%b eni=%b required 1 0 0 0",
                     ok, mode, enable_game_classic, enable_game_infinity);
        end
        release_btn(4);
    endtask

    task automatic test_abort_and_reset();
        bit done = 1'b0;
        press(1, "r");
        release_btn(1);
        press(4, "c");
        release_btn(4);
        total++;
        if (mode !== 3'd2) begin
            bad++;
            $display("FAIL abort_setup: mode=%0d required=2", mode);
        end
        sw_raw[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (mode === 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        total++;
        if (done !== 1'b1 || sw[0] !== 1'b1 || enable_game_infinity !== 1'b0) begin
            bad++;
            $display("FAIL abort: reached_menu=%b sw0=%b eni=%b required 1 1 0", done, sw[0], enable_game_infinity);
        end
        sw_raw[0] = 1'b0;
        repeat (20) step();
        press(0, "l");
        release_btn(0);
        press(4, "c");
        release_btn(4);
        total++;
        if (mode !== 3'd1) begin
            bad++;
            $display("FAIL reset_setup: mode=%0d required=1", mode);
        end
        btn_raw[4] = 1'b1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mode !== 3'd0 || enable_game_classic !== 1'b0 || enable_game_infinity !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: mode=%0d enc=%b eni=%b required 0 0 0", mode, enable_game_classic, enable_game_infinity);
        end
        repeat (3) step();
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (btn_pulse !== 5'd0 || mode !== 3'd0) seen++;
            end
            total++;
            if (seen != 0) begin
                bad++;
                $display("FAIL post_reset_pulse: cycles with pulse or mode!=0 =%0d required=0", seen);
            end
        end
        release_btn(4);
    endtask

    initial begin
        rst_n              = 1'b0;
        sw_raw             = '0;
        btn_raw            = '0;
        game_over_classic  = 1'b0;
        game_over_infinity = 1'b0;
        test_reset();
        test_debounce();
        test_start_infinity();
        test_l_and_r();
        test_pause_resume();
        test_coincident();
        test_abort_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_input_ctrl.md
# game_input_ctrl

Front-end input block for the game top level, sitting upstream of the segment/LED display driver. It synchronises and debounces the raw board switches and push-buttons, produces clean switch levels and one-cycle button pulses, and runs the game-selection state machine. That state machine generates `mode`, `enable_game_classic` and `enable_game_infinity`, which the display driver and both game engines consume.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: clk cycles between debounce sample ticks (10 ms at 100 MHz); must be ≥ 2.
- `N_SAMPLES`, default 3: number of consecutive agreeing samples required to accept a new level; must be ≥ 2.

- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw_raw`  in  16  raw slide switches, asynchronous to `clk`.
- `btn_raw`  in  5  raw buttons `{C,D,U,R,L}` (index 0 = L, 4 = C), asynchronous.
- `game_over_classic`  in  1  one-cycle pulse from the classic engine.
- `game_over_infinity`  in  1  one-cycle pulse from the infinity engine.
- `sw`  out  16  debounced switch levels.
- `btn_pulse`  out  5  one-cycle pulse on each debounced 0→1 button edge.
- `mode`  out  3  `0` MENU, `1` CLASSIC, `2` INFINITY, `4` PAUSE.
- `menu_sel`  out  1  current menu cursor: 0 = classic, 1 = infinity.
- `enable_game_classic`  out  1  classic game active (running or paused).
- `enable_game_infinity`  out  1  infinity game active (running or paused).

## Operation
**Input path**
- Every raw input passes through a 2-flop synchroniser.
- A shared prescaler counts 0..`DEBOUNCE_CYCLES`-1 and asserts `tick` for one cycle at wrap.
- On each `tick`, every synchronised input shifts into its own `N_SAMPLES`-deep history.
- The debounced level updates only when all `N_SAMPLES` entries agree and differ from the current level. Otherwise the level holds.
- `btn_pulse[i]` = debounced level high AND previous-cycle debounced level low. It is exactly one `clk` wide.

**State machine** (`PAUSE` remembers the game via `menu_sel`)
- **MENU**
  - `L` pulse: `menu_sel` ← 0.
  - `R` pulse: `menu_sel` ← 1.
  - `L` and `R` in the same cycle: no change.
  - `C` pulse: go to CLASSIC if `menu_sel` = 0, INFINITY if `menu_sel` = 1.
- **CLASSIC / INFINITY**
  - `C` pulse: go to PAUSE.
  - The matching `game_over_*`: go to MENU.
  - `sw[0]` debounced high: go to MENU (abort).
- **PAUSE**
  - `C` pulse: return to the game selected by `menu_sel`.
  - Matching `game_over_*` or `sw[0]` high: go to MENU.
- Priority when events coincide: `sw[0]` abort > `game_over` > `C` > `L`/`R`.
- A `game_over_*` for the non-active game is ignored.
- `enable_game_classic` = state ∈ {CLASSIC, PAUSE with `menu_sel` = 0}.
- `enable_game_infinity` = state ∈ {INFINITY, PAUSE with `menu_sel` = 1}.
- The two enables are never high together.
- `menu_sel` is frozen outside MENU.

## Timing
- Reset (asserted asynchronously, released synchronously by design usage) forces:
  - prescaler and histories to 0;
  - `sw` = 0, `btn_pulse` = 0;
  - state MENU, `mode` = 0, `menu_sel` = 0;
  - both enables = 0.
- All outputs are registered.
- Raw-to-debounced latency: 2 sync cycles, plus between `N_SAMPLES`-1 and `N_SAMPLES` ticks, plus 1 register cycle.
- `btn_pulse` appears 1 cycle after the debounced level rises.
- State, `mode` and enables update 1 cycle after the causing pulse.
- A button held indefinitely produces a single pulse. A glitch shorter than (`N_SAMPLES`-1)·`DEBOUNCE_CYCLES` cycles produces none.
- Reset mid-game returns to MENU with enables low on the first cycle of reset. No pulse is emitted on release, even if a button is held, because histories and levels restart at 0 and need `N_SAMPLES` ticks.
- The prescaler wraps silently; its width is `$clog2(DEBOUNCE_CYCLES)`.

## Structure
- Shared package `game_pkg`:
  - mode encodings `MODE_MENU`/`MODE_CLASSIC`/`MODE_INFINITY`/`MODE_PAUSE`;
  - button indices `BTN_L`, `BTN_R`, `BTN_U`, `BTN_D`, `BTN_C`;
  - FSM state enum.
- One sub-module, `game_debounce`: a 1-bit synchroniser plus sample history plus level register, taking `tick` as an input. It is instantiated 21 times via generate.
- The prescaler, edge detect and FSM live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `N_SAMPLES` = 3.
1. **Reset values:** hold `rst_n` = 0 with random raw inputs → all outputs 0 and `mode` = 0. Release, keep inputs low for 100 cycles → outputs unchanged.
2. **Debounce:** `btn_raw[4]` high for 6 cycles then low → no `btn_pulse`. Held high for 40 cycles → exactly one `btn_pulse[4]`, 11–15 cycles after the rise.
3. **Start infinity:** in MENU, pulse `R` then `C` → `menu_sel` = 1, `mode` = 2, `enable_game_infinity` = 1, `enable_game_classic` = 0.
4. **Pause/resume:** in CLASSIC, press `C` → `mode` = 4 with `enable_game_classic` still 1. Press `C` again → `mode` = 1.
5. **Coincident events:** in CLASSIC, assert `game_over_classic` in the same cycle as a `C` pulse → next cycle `mode` = 0, enables 0. In INFINITY, `game_over_classic` → no change.
6. **Abort and reset mid-game:** in INFINITY, set `sw_raw[0]` = 1 → after debounce, `mode` = 0. In CLASSIC, pulse `rst_n` low while `C` is held → `mode` = 0 immediately, and no `btn_pulse` within 8 cycles after release.
